// File: rtl/pause_gate.sv
// Core-side pause responder: waits for a frame-safe point (vblank rising edge or timeout),
// gates the core clock enable, and holds the acknowledge/mute through a settle period on release.
module pause_gate #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000,
    parameter int unsigned RESUME_DELAY   = 16
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pause_core,
    input  logic vblank,
    input  logic ce_in,
    output logic ce_out,
    output logic paused,
    output logic mute
);

    localparam int RW = $clog2(RESUME_DELAY + 1);
    localparam logic [RW-1:0] RES_LOAD = RW'(RESUME_DELAY);
    localparam logic [RW-1:0] RES_ONE  = RW'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_VB = 2'd1,
        PAUSED  = 2'd2,
        RESUME  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          vblank_q;
    logic [23:0]   tmo_q, tmo_d;
    logic [RW-1:0] res_q, res_d;
    logic          gate_q;
    logic          ack_q, ack_d;
    logic          vb_rise;
    logic          tmo_hit;

    assign vb_rise = vblank & ~vblank_q;
    assign tmo_hit = (tmo_q == TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        res_d   = res_q;
        ack_d   = ack_q;
        case (state_q)
            RUN: begin
                ack_d = 1'b0;
                if (pause_core) begin
                    state_d = WAIT_VB;
                    tmo_d   = '0;
                end
            end
            WAIT_VB: begin
                // Saturating count; ack is held so a re-pause from RESUME keeps reporting paused.
                if (tmo_q != '1) begin
                    tmo_d = tmo_q + 24'd1;
                end
                if (!pause_core) begin
                    state_d = RUN;
                    ack_d   = 1'b0;
                end else if (vb_rise || tmo_hit) begin
                    state_d = PAUSED;
                    ack_d   = 1'b1;
                end
            end
            PAUSED: begin
                ack_d = 1'b1;
                if (!pause_core) begin
                    state_d = RESUME;
                    res_d   = RES_LOAD;
                end
            end
            RESUME: begin
                ack_d = 1'b1;
                if (pause_core) begin
                    state_d = WAIT_VB;
                    tmo_d   = '0;
                end else if (ce_in) begin
                    res_d = res_q - RES_ONE;
                    if (res_q == RES_ONE) begin
                        state_d = RUN;
                        ack_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = RUN;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            vblank_q <= 1'b0;
            tmo_q    <= '0;
            res_q    <= '0;
            gate_q   <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vblank_q <= vblank;
            tmo_q    <= tmo_d;
            res_q    <= res_d;
            gate_q   <= (state_d != PAUSED);
            ack_q    <= ack_d;
        end
    end

    // reset_n in the product keeps the core frozen for the whole asynchronous reset window.
    assign ce_out = ce_in & gate_q & reset_n;
    assign paused = ack_q;
    assign mute   = ack_q;

endmodule
